// File: rtl/memory_sdp_param_pkg.sv
// Shared definitions for the simple-dual-port RAM: the init/ready FSM encoding
// and the byte-lane width used to split data words into write-enable lanes.
package memory_sdp_param_pkg;

  localparam int unsigned MEM_BYTE_W = 8;

  typedef enum logic [0:0] {
    MEM_FSM_INIT  = 1'b0,
    MEM_FSM_READY = 1'b1
  } mem_fsm_e;

endpackage

// File: rtl/memory_sdp_param_init_sweep.sv
// Post-reset zero-fill sequencer: walks every address once, then parks in READY
// until the next reset.
module memory_init_sweep
  import memory_sdp_param_pkg::*;
#(
  parameter int unsigned ADDR_W  = 7,
  parameter bit          INIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              sweep_vld,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  mem_fsm_e          state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT_EN ? MEM_FSM_INIT : MEM_FSM_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sweep_vld = 1'b0;
    case (state_q)
      MEM_FSM_INIT: begin
        sweep_vld = ~reset;
        cnt_d     = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_ADDR) state_d = MEM_FSM_READY;
      end
      MEM_FSM_READY: state_d = MEM_FSM_READY;
      default:       state_d = MEM_FSM_INIT;
    endcase
  end

  assign sweep_addr = cnt_q;
  // Masked by reset so the ports read as not-ready while reset is held,
  // even when the state register already sits in READY (no-sweep build).
  assign init_done  = (state_q == MEM_FSM_READY) & ~reset;

endmodule

// File: rtl/memory_sdp_param.sv
// Simple-dual-port RAM with byte enables, request/valid reads, optional output
// register, write-first collision forwarding and post-reset zero fill.
module memory_sdp_param
  import memory_sdp_param_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned OUT_REG = 1,
  parameter int unsigned INIT_EN = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_vld,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [WIDTH/MEM_BYTE_W-1:0] wr_be,
  input  logic                      rd_req,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic                      rd_vld,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      init_done
);

  localparam int unsigned BE_W  = WIDTH / MEM_BYTE_W;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  // Field widths follow the instance parameters, so the port bundles live here.
  typedef struct packed {
    logic              wr_vld;
    logic [ADDR_W-1:0] wr_addr;
    logic [BE_W-1:0]   wr_be;
  } mem_wr_t;

  typedef struct packed {
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
  } mem_rd_t;

  logic              sweep_vld;
  logic [ADDR_W-1:0] sweep_addr;

  memory_init_sweep #(
    .ADDR_W  (ADDR_W),
    .INIT_EN (INIT_EN != 0)
  ) u_sweep (
    .clk        (clk),
    .reset      (reset),
    .sweep_vld  (sweep_vld),
    .sweep_addr (sweep_addr),
    .init_done  (init_done)
  );

  mem_wr_t          wr_s;
  logic [WIDTH-1:0] wr_wdata;

  always_comb begin
    if (init_done) begin
      wr_s.wr_vld  = wr_vld;
      wr_s.wr_addr = wr_addr;
      wr_s.wr_be   = wr_be;
      wr_wdata     = wr_data;
    end else begin
      wr_s.wr_vld  = sweep_vld;
      wr_s.wr_addr = sweep_addr;
      wr_s.wr_be   = '1;
      wr_wdata     = '0;
    end
  end

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_s.wr_vld) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (wr_s.wr_be[i])
          mem_q[wr_s.wr_addr][MEM_BYTE_W*i +: MEM_BYTE_W] <= wr_wdata[MEM_BYTE_W*i +: MEM_BYTE_W];
      end
    end
  end

  mem_rd_t rd_s1_q, rd_s1_d;

  always_comb begin
    rd_s1_d.rd_req  = rd_req & init_done;
    rd_s1_d.rd_addr = rd_s1_d.rd_req ? rd_addr : rd_s1_q.rd_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_s1_q <= '0;
    else       rd_s1_q <= rd_s1_d;
  end

  // A write landing in the array-read cycle has not reached mem_q yet, so its
  // enabled byte lanes are substituted here to give write-first behaviour.
  logic [WIDTH-1:0] fwd_data;

  always_comb begin
    fwd_data = mem_q[rd_s1_q.rd_addr];
    if (wr_s.wr_vld && (wr_s.wr_addr == rd_s1_q.rd_addr)) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (wr_s.wr_be[i])
          fwd_data[MEM_BYTE_W*i +: MEM_BYTE_W] = wr_wdata[MEM_BYTE_W*i +: MEM_BYTE_W];
      end
    end
  end

  logic             s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;

  always_comb begin
    s2_vld_d  = rd_s1_q.rd_req;
    s2_data_d = rd_s1_q.rd_req ? fwd_data : s2_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
    end else begin
      s2_vld_q  <= s2_vld_d;
      s2_data_q <= s2_data_d;
    end
  end

  // Without the output register, S2 still serves as the hold register for
  // rd_data between valid pulses.
  generate
    if (OUT_REG != 0) begin : g_out_reg
      assign rd_vld  = s2_vld_q & ~reset;
      assign rd_data = s2_data_q;
    end else begin : g_out_comb
      assign rd_vld  = rd_s1_q.rd_req & ~reset;
      assign rd_data = (rd_s1_q.rd_req & ~reset) ? fwd_data : s2_data_q;
    end
  endgenerate

endmodule

// File: tb/tb_memory_sdp_param.sv
// Directed bench: DUT 0 is the default build (OUT_REG=1, INIT_EN=1), DUT 1 the
// low-latency build without zero fill (OUT_REG=0, INIT_EN=0).
module tb_memory_sdp_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       reset;
  logic [1:0]       wr_vld;
  logic [1:0][6:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic [1:0][3:0]  wr_be;
  logic [1:0]       rd_req;
  logic [1:0][6:0]  rd_addr;
  logic [1:0]       rd_vld;
  logic [1:0][31:0] rd_data;
  logic [1:0]       init_done;

  int vectors = 0;
  int miscompares = 0;

  memory_sdp_param #(
    .WIDTH(32), .ADDR_W(7), .OUT_REG(1), .INIT_EN(1)
  ) dut_a (
    .clk(clk), .reset(reset[0]), .wr_vld(wr_vld[0]), .wr_addr(wr_addr[0]),
    .wr_data(wr_data[0]), .wr_be(wr_be[0]), .rd_req(rd_req[0]), .rd_addr(rd_addr[0]),
    .rd_vld(rd_vld[0]), .rd_data(rd_data[0]), .init_done(init_done[0])
  );

  memory_sdp_param #(
    .WIDTH(32), .ADDR_W(7), .OUT_REG(0), .INIT_EN(0)
  ) dut_b (
    .clk(clk), .reset(reset[1]), .wr_vld(wr_vld[1]), .wr_addr(wr_addr[1]),
    .wr_data(wr_data[1]), .wr_be(wr_be[1]), .rd_req(rd_req[1]), .rd_addr(rd_addr[1]),
    .rd_vld(rd_vld[1]), .rd_data(rd_data[1]), .init_done(init_done[1])
  );

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end of the test sequence");
    $fatal(1, "timeout");
  end

  task automatic do_write(input int d, input logic [6:0] a, input logic [31:0] data,
                          input logic [3:0] be);
    @(negedge clk);
    wr_vld[d] = 1'b1; wr_addr[d] = a; wr_data[d] = data; wr_be[d] = be;
    @(negedge clk);
    wr_vld[d] = 1'b0;
  endtask

  task automatic do_read(input int d, input logic [6:0] a, input logic [31:0] exp,
                         input string name);
    int lat = (d == 0) ? 2 : 1;
    @(negedge clk);
    rd_req[d] = 1'b1; rd_addr[d] = a;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      rd_req[d] = 1'b0;
      #1;
      vectors++;
      if (rd_vld[d] !== (k == lat)) begin
        miscompares++;
        $display("FAIL %s dut%0d rd_vld cycle +%0d: got %b expected %b", name, d, k, rd_vld[d], (k == lat));
      end
      if (k == lat) begin
        vectors++;
        if (rd_data[d] !== exp) begin
          miscompares++;
          $display("FAIL %s dut%0d rd_data: got %h expected %h", name, d, rd_data[d], exp);
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 2'b11; wr_vld = '0; rd_req = '0;
    wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      vectors += 3;
      if (rd_vld[d] !== 1'b0) begin miscompares++; $display("FAIL reset_rd_vld dut%0d: got %b expected 0", d, rd_vld[d]); end
      if (rd_data[d] !== 32'h0) begin miscompares++; $display("FAIL reset_rd_data dut%0d: got %h expected 0", d, rd_data[d]); end
      if (init_done[d] !== 1'b0) begin miscompares++; $display("FAIL reset_init_done dut%0d: got %b expected 0", d, init_done[d]); end
    end
  endtask

  task automatic test_init_sweep;
    @(negedge clk);
    reset[0] = 1'b0;
    #1;
    vectors++;
    if (init_done[0] !== 1'b0) begin miscompares++; $display("FAIL init_done_early dut0: got %b expected 0", init_done[0]); end
    for (int k = 1; k <= 128; k++) begin
      @(negedge clk); #1;
      if (k >= 127) begin
        vectors++;
        if (init_done[0] !== (k == 128)) begin
          miscompares++;
          $display("FAIL init_done_timing dut0 cycle %0d: got %b expected %b", k + 1, init_done[0], (k == 128));
        end
      end
    end
    do_read(0, 7'd0, 32'h0, "init_zero_addr0");
    do_read(0, 7'd127, 32'h0, "init_zero_addr127");
  endtask

  task automatic test_init_direct;
    @(negedge clk);
    reset[1] = 1'b0;
    #1;
    vectors++;
    if (init_done[1] !== 1'b1) begin miscompares++; $display("FAIL init_direct dut1: got %b expected 1", init_done[1]); end
  endtask

  task automatic test_byte_enable(input int d);
    do_write(d, 7'd5, 32'hDEADBEEF, 4'hF);
    do_write(d, 7'd5, 32'h11223344, 4'b0101);
    do_read(d, 7'd5, 32'hDE22BE44, "byte_enable");
    do_write(d, 7'd5, 32'h55555555, 4'h0);
    do_read(d, 7'd5, 32'hDE22BE44, "be_zero_noop");
  endtask

  task automatic collide(input int d, input int wr_off, input string name);
    int lat = (d == 0) ? 2 : 1;
    do_write(d, 7'd9, 32'h0, 4'hF);
    @(negedge clk);
    rd_req[d] = 1'b1; rd_addr[d] = 7'd9;
    wr_addr[d] = 7'd9; wr_data[d] = 32'hAAAAAAAA; wr_be[d] = 4'b0011;
    wr_vld[d] = (wr_off == 0);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      rd_req[d] = 1'b0;
      wr_vld[d] = (k == wr_off);
      #1;
      vectors++;
      if (rd_vld[d] !== (k == lat)) begin
        miscompares++;
        $display("FAIL %s dut%0d rd_vld cycle +%0d: got %b expected %b", name, d, k, rd_vld[d], (k == lat));
      end
      if (k == lat) begin
        vectors++;
        if (rd_data[d] !== 32'h0000AAAA) begin
          miscompares++;
          $display("FAIL %s dut%0d rd_data: got %h expected 0000aaaa", name, d, rd_data[d]);
        end
      end
    end
    wr_vld[d] = 1'b0;
  endtask

  task automatic test_collision(input int d);
    collide(d, 1, "collision_array_cycle");
    collide(d, 0, "collision_request_cycle");
  endtask

  task automatic test_back_to_back(input int d);
    int lat = (d == 0) ? 2 : 1;
    for (int i = 0; i < 4; i++) do_write(d, 7'(i), 32'(i + 1), 4'hF);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rd_req[d] = (c < 4); rd_addr[d] = 7'(c);
      #1;
      vectors++;
      if (rd_vld[d] !== (c >= lat && c < lat + 4)) begin
        miscompares++;
        $display("FAIL stream_vld dut%0d cycle %0d: got %b expected %b", d, c, rd_vld[d], (c >= lat && c < lat + 4));
      end
      if (c >= lat && c < lat + 4) begin
        vectors++;
        if (rd_data[d] !== 32'(c - lat + 1)) begin
          miscompares++;
          $display("FAIL stream_data dut%0d cycle %0d: got %h expected %h", d, c, rd_data[d], 32'(c - lat + 1));
        end
      end
    end
    rd_req[d] = 1'b0;
  endtask

  task automatic test_reset_midflight;
    int pulses = 0;
    @(negedge clk); rd_req[0] = 1'b1; rd_addr[0] = 7'd0;
    @(negedge clk); rd_req[0] = 1'b1; rd_addr[0] = 7'd1;
    @(negedge clk); rd_req[0] = 1'b0; reset[0] = 1'b1;
    #1;
    if (rd_vld[0] === 1'b1) pulses++;
    repeat (4) begin
      @(negedge clk); #1;
      if (rd_vld[0] === 1'b1) pulses++;
    end
    vectors++;
    if (init_done[0] !== 1'b0) begin miscompares++; $display("FAIL midflight_init_done dut0: got %b expected 0", init_done[0]); end
    @(negedge clk);
    reset[0] = 1'b0;
    for (int k = 1; k <= 128; k++) begin
      @(negedge clk);
      wr_vld[0] = (k == 50); wr_addr[0] = 7'd0; wr_data[0] = 32'hFFFFFFFF; wr_be[0] = 4'hF;
      rd_req[0] = (k == 60); rd_addr[0] = 7'd3;
      #1;
      if (rd_vld[0] === 1'b1) pulses++;
      if (k >= 127) begin
        vectors++;
        if (init_done[0] !== (k == 128)) begin
          miscompares++;
          $display("FAIL resweep_init_done dut0 cycle %0d: got %b expected %b", k + 1, init_done[0], (k == 128));
        end
      end
    end
    wr_vld[0] = 1'b0; rd_req[0] = 1'b0;
    @(negedge clk); #1;
    if (rd_vld[0] === 1'b1) pulses++;
    vectors++;
    if (pulses !== 0) begin miscompares++; $display("FAIL midflight_rd_vld dut0: got %0d pulses expected 0", pulses); end
    do_read(0, 7'd0, 32'h0, "dropped_write_addr0");
    do_read(0, 7'd1, 32'h0, "resweep_addr1");
    do_read(0, 7'd5, 32'h0, "resweep_addr5");
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_init_direct();
    for (int d = 0; d < 2; d++) begin
      test_byte_enable(d);
      test_collision(d);
      test_back_to_back(d);
    end
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
